// File: rtl/dmem_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, word-offset mask.
// Combinational definitions only; no latency or backpressure of its own.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic [31:0] WORD_OFS_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering: extracts/extends a load lane and merges store data into a read word.
// Purely combinational, zero latency, no flow control.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  i_ofs,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_ofs)
      2'd0: w_byte = i_rd[7:0];
      2'd1: w_byte = i_rd[15:8];
      2'd2: w_byte = i_rd[23:16];
      2'd3: w_byte = i_rd[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_ofs[1] ? i_rd[31:16] : i_rd[15:0];

    o_load = i_rd;
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_rd;
    endcase

    o_merge = i_rd;
    case (i_size)
      SZ_BYTE: begin
        case (i_ofs)
          2'd0: o_merge[7:0]   = i_wdata[7:0];
          2'd1: o_merge[15:8]  = i_wdata[7:0];
          2'd2: o_merge[23:16] = i_wdata[7:0];
          2'd3: o_merge[31:24] = i_wdata[7:0];
          default: o_merge = i_rd;
        endcase
      end
      SZ_HALF: begin
        if (i_ofs[1]) o_merge[31:16] = i_wdata[15:0];
        else          o_merge[15:0]  = i_wdata[15:0];
      end
      SZ_WORD: o_merge = i_wdata;
      default: o_merge = i_rd;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte/half/word load-store unit over a word-wide dmem; sub-word stores use read-modify-write.
// Response 1 cycle after accept on error, 2 for load/word store, 3 for sub-word store; ready only in IDLE.
// Optional DMEM_LSU_RANGE_CHECK_EN rejects addresses beyond MEM_WORDS.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_resp_rdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_a,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  size_e       r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_range_err;
  logic        w_req_err;
  logic [31:0] w_lane_load;
  logic [31:0] w_lane_merge;

`ifdef DMEM_LSU_RANGE_CHECK_EN
  assign w_range_err = (i_req_addr[31:2] >= 30'(MEM_WORDS));
`else
  assign w_range_err = 1'b0;
`endif

  assign w_req_err = (i_req_size == SZ_ILL)
                   | ((i_req_size == SZ_HALF) & i_req_addr[0])
                   | ((i_req_size == SZ_WORD) & (|i_req_addr[1:0]))
                   | w_range_err;

  assign w_accept = i_req_valid & (r_state == ST_IDLE) & ~i_reset;

  dmem_lsu_lane u_lane (
    .i_ofs      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rd       (i_mem_rd),
    .i_wdata    (r_wdata),
    .o_load     (w_lane_load),
    .o_merge    (w_lane_merge)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_a      = 32'h0;
    o_mem_wd     = 32'h0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = ~i_reset;
        if (w_accept) begin
          if (w_req_err)              w_next = ST_RESP;
          else if (!i_req_we)         w_next = ST_LOAD;
          else if (i_req_size == SZ_WORD) w_next = ST_WRITE;
          else                        w_next = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        o_mem_a = r_addr & ~WORD_OFS_MASK;
        w_next  = ST_RESP;
      end
      ST_RMW_RD: begin
        o_mem_a = r_addr & ~WORD_OFS_MASK;
        w_next  = ST_WRITE;
      end
      ST_WRITE: begin
        // Gated so a reset landing on the write cycle cannot commit a partial store.
        o_mem_we = ~i_reset;
        o_mem_a  = r_addr & ~WORD_OFS_MASK;
        o_mem_wd = (r_size == SZ_WORD) ? r_wdata : r_merge;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_merge      <= 32'h0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= size_e'(i_req_size);
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_resp_err <= w_req_err;
            if (w_req_err) r_resp_rdata <= 32'h0;
          end
        end
        ST_LOAD:   r_resp_rdata <= w_lane_load;
        ST_RMW_RD: r_merge      <= w_lane_merge;
        ST_WRITE:  r_resp_rdata <= 32'h0;
        default: ;
      endcase
    end
  end

  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

  logic w_unused;
  assign w_unused = r_we;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the core's memory-stage request and the word-wide `dmem` (combinational read `rd`, write on rising `clk` when `we`). It is the initiator side of the `dmem` interface. It adds byte and halfword accesses on top of the word-only memory, performing read-modify-write for sub-word stores. It uses a valid/ready request and a one-cycle response pulse, so the core stalls while an access is in flight.

## Interface
- `MEM_WORDS`, 64: number of 32-bit words backing `dmem`; used only by the range check.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  request rejected (misaligned / illegal size / out of range); qualified by `resp_valid`
- `resp_rdata`  out  32  extended load data; 0 for stores and errors; held until next response
- `mem_we`  out  1  to `dmem.we`
- `mem_a`  out  32  to `dmem.a`, always word-aligned (`req_addr & ~3`)
- `mem_wd`  out  32  to `dmem.wd`
- `mem_rd`  in  32  from `dmem.rd`

## Operation
- Byte lanes are little-endian: offset 0 = [7:0] … offset 3 = [31:24]; half at offset 0 = [15:0], offset 2 = [31:16].
- States:
  - IDLE: `req_ready`=1. The handshake `req_valid && req_ready` latches `we`, `size`, `unsigned`, `addr` and `wdata`.
  - Transitions out of IDLE: error → RESP; load → LOAD; word store → WRITE; byte/half store → RMW_RD.
  - LOAD: drive `mem_a`, extract the addressed lane from `mem_rd`, extend it, register into `resp_rdata` → RESP.
  - RMW_RD: drive `mem_a`, register the merge word = `mem_rd` with the addressed lane replaced by the store data → WRITE.
  - WRITE: `mem_we`=1, `mem_wd` = latched word (word store) or merge word → RESP.
  - RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- Error conditions, which cause no memory access: size 11; half with `addr[0]`=1; word with `addr[1:0]`≠0. The range check adds a further condition (see Configuration).
- `mem_we` is high only in WRITE and is gated by `!reset`. `mem_a`/`mem_wd` are 0 in IDLE and RESP.
- Outputs are Moore (decoded from state and registers). `req_ready` is never high during reset or outside IDLE.

## Timing
- Cycle 0 is the handshake cycle.
- Latency to `resp_valid`:
  - error: cycle 1
  - load / word store: cycle 2
  - sub-word store: cycle 3
- Throughput: next request accepted the cycle after RESP.
- The memory write occurs at the rising edge ending the WRITE cycle.
- Reset values: state IDLE; `resp_valid`, `resp_err`, `mem_we` = 0; `resp_rdata`, `mem_a`, `mem_wd` = 0; `req_ready` = 0 while `reset` is high, then 1.
- Reset mid-operation aborts the access: no write is issued, no response is produced, and IDLE follows on the next cycle.
- `req_valid` with `req_ready`=0 is ignored. The requester holds the request until accepted.

## Configuration
- `DMEM_LSU_RANGE_CHECK_EN` defined: `addr[31:2] >= MEM_WORDS` is an error (RESP at cycle 1, `resp_err`=1, no access).
- Macro undefined: no range logic; out-of-range addresses pass to `dmem` unchanged and complete normally.

## Structure
- `dmem_lsu_pkg` holds:
  - size enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`)
  - state enum (IDLE, LOAD, RMW_RD, WRITE, RESP)
  - word-offset mask constant
- Sub-module `dmem_lsu_lane` is purely combinational. From offset, size and unsigned it produces:
  - the extracted/extended load word from a 32-bit read word
  - the merged store word from the read word plus store data
- The FSM, request latches and response registers live in `dmem_lsu`.

## Test plan
- Bench setup: `dmem_lsu` wired to a real `dmem`.
- Word store `0xA5A5A5A5` @0x4 → `mem_we` high in cycle 1 only, `mem_a`=0x4, `mem_wd`=0xA5A5A5A5, `resp_valid` cycle 2, `resp_err`=0. Then word load @0x4 → `resp_rdata`=0xA5A5A5A5 at cycle 2.
- After test 1, byte store `0x3C` @0x5 → RMW_RD cycle 1, write of 0xA5A53CA5 in cycle 2, response cycle 3. Subsequent byte loads:
  - signed @0x5 → 0x0000003C
  - signed @0x7 → 0xFFFFFFA5
  - unsigned @0x7 → 0x000000A5
- Word 0x5A5A5A5A @0x8, then half store `0xBEEF` @0xA → word = 0xBEEF5A5A. Subsequent half loads @0xA:
  - signed → 0xFFFFBEEF
  - unsigned → 0x0000BEEF
- Misaligned word store @0x6, half load @0x9, and size 11 → `resp_valid` and `resp_err`=1 at cycle 1, `mem_we` never high, word @0x4 unchanged.
- `reset` pulsed during WRITE of a byte store @0x4 → `mem_we` low that cycle, no `resp_valid`, `req_ready`=1 the cycle after reset drops, word @0x4 unchanged.
- Range check, `MEM_WORDS`=64, word load @0x100:
  - macro defined → `resp_err`=1 at cycle 1, no access
  - macro undefined → normal access, `resp_err`=0 at cycle 2
